// File: rtl/score_low_digits.sv
// Two-digit crossing counter for the frog game: samples the top row once per tick,
// scores each frog arrival once, and drives active-low 7-seg ones/tens digits plus a wrap carry.
module score_low_digits #(
    parameter int TICK_DIV = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       crash,
    input  logic [7:0] redInput,
    output logic [6:0] h0,
    output logic [6:0] h1,
    output logic       carry,
    output logic [6:0] count
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {ARMED, SCORED} state_t;

    state_t        state_p0, state_nxt;
    logic [CW-1:0] tick_cnt_p0;
    logic          tick;
    logic          inc_nxt, inc_p1;
    logic [3:0]    ones_p2, tens_p2;
    logic          carry_p2;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Stage 0: free-running tick divider and top-row sampling FSM
    assign tick = (tick_cnt_p0 == TICK_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_p0 <= '0;
            state_p0    <= ARMED;
        end else begin
            tick_cnt_p0 <= tick ? '0 : tick_cnt_p0 + CW'(1);
            state_p0    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        inc_nxt   = 1'b0;
        if (tick) begin
            case (state_p0)
                ARMED: begin
                    if (redInput != 8'd0 && !crash) begin
                        state_nxt = SCORED;
                        inc_nxt   = 1'b1;
                    end
                end
                SCORED: begin
                    if (redInput == 8'd0)
                        state_nxt = ARMED;
                end
                default: state_nxt = ARMED;
            endcase
        end
    end

    // Stage 1: registered increment request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            inc_p1 <= 1'b0;
        else
            inc_p1 <= inc_nxt;
    end

    // Stage 2: BCD digits and wrap carry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ones_p2  <= 4'd0;
            tens_p2  <= 4'd0;
            carry_p2 <= 1'b0;
        end else begin
            carry_p2 <= 1'b0;
            if (inc_p1) begin
                if (ones_p2 != 4'd9) begin
                    ones_p2 <= ones_p2 + 4'd1;
                end else begin
                    ones_p2 <= 4'd0;
                    if (tens_p2 != 4'd9) begin
                        tens_p2 <= tens_p2 + 4'd1;
                    end else begin
                        tens_p2  <= 4'd0;
                        carry_p2 <= 1'b1;
                    end
                end
            end
        end
    end

    assign h0    = seg7(ones_p2);
    assign h1    = seg7(tens_p2);
    assign carry = carry_p2;
    assign count = {3'd0, tens_p2} * 7'd10 + {3'd0, ones_p2};

endmodule

// File: tb/tb_score_low_digits.sv
// Randomized bench for score_low_digits against a score-level reference model.
module tb_score_low_digits;

    localparam int DIV = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       crash = 1'b0;
    logic [7:0] redInput = 8'd0;
    logic [6:0] h0, h1, count;
    logic       carry;

    int n_vec  = 0;
    int n_miss = 0;
    int carry_seen = 0;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference: score as a plain integer, frog presence flag, scheduled increment cycle
    int m_cyc   = 0;
    int m_score = 0;
    int m_due   = -1;
    bit m_home  = 1'b0;
    bit m_carry = 1'b0;

    score_low_digits #(.TICK_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .crash(crash), .redInput(redInput),
        .h0(h0), .h1(h1), .carry(carry), .count(count)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_score = 0; m_due = -1; m_home = 1'b0; m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (m_due == m_cyc) begin
                m_score = (m_score + 1) % 100;
                m_carry = (m_score == 0);
                m_due = -1;
            end
            if (m_cyc % DIV == DIV - 1) begin
                if (!m_home && redInput != 8'd0 && !crash) begin
                    m_home = 1'b1;
                    m_due  = m_cyc + 1;
                end else if (m_home && redInput == 8'd0) begin
                    m_home = 1'b0;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        chk("count", 32'(count), 32'(m_score));
        chk("h0", 32'(h0), 32'(seg[m_score % 10]));
        chk("h1", 32'(h1), 32'(seg[m_score / 10]));
        chk("carry", 32'(carry), 32'(m_carry));
        if (carry === 1'b1) carry_seen = carry_seen + 1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic crossing();
        redInput = 8'($urandom_range(1, 255));
        crash = 1'b0;
        run(DIV);
        redInput = 8'd0;
        run(DIV);
    endtask

    task automatic reach(input int target);
        int guard = 0;
        while (m_score != target && guard < 200) begin
            crossing();
            guard++;
        end
        chk("reach", 32'(count), 32'(target));
    endtask

    initial begin
        bit found;
        // Reset held low, then idle
        repeat (3) cycle();
        chk("rst_h0", 32'(h0), 32'(7'b1000000));
        chk("rst_h1", 32'(h1), 32'(7'b1000000));
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        run(1);
        chk("rel_count", 32'(count), 32'd0);
        run(3 * DIV);
        chk("idle_count", 32'(count), 32'd0);

        // Resting frog scores once
        redInput = 8'h10;
        run(5 * DIV);
        chk("rest_count", 32'(count), 32'd1);
        chk("rest_h0", 32'(h0), 32'(7'b1111001));
        redInput = 8'h00; run(DIV);
        redInput = 8'h01; run(DIV);
        redInput = 8'h00; run(DIV);
        chk("second_count", 32'(count), 32'd2);
        chk("second_h0", 32'(h0), 32'(7'b0100100));

        // Crash blocks scoring until it drops
        crash = 1'b1; redInput = 8'h80;
        run(3 * DIV);
        chk("crash_count", 32'(count), 32'd2);
        crash = 1'b0;
        run(DIV);
        chk("postcrash_count", 32'(count), 32'd3);
        redInput = 8'h00; run(DIV);

        // Ones-to-tens rollover
        reach(9);
        chk("nine_h0", 32'(h0), 32'(7'b0010000));
        chk("nine_h1", 32'(h1), 32'(7'b1000000));
        crossing();
        chk("ten_h0", 32'(h0), 32'(7'b1000000));
        chk("ten_h1", 32'(h1), 32'(7'b1111001));
        chk("ten_count", 32'(count), 32'd10);

        // Random top-row and crash activity, one decision per tick window
        for (int i = 0; i < 60; i++) begin
            redInput = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            crash    = ($urandom_range(0, 3) == 0);
            run(DIV);
        end
        crash = 1'b0; redInput = 8'd0; run(DIV);

        // 99 -> 00 wrap with single-cycle carry
        reach(99);
        chk("99_h0", 32'(h0), 32'(7'b0010000));
        chk("99_h1", 32'(h1), 32'(7'b0010000));
        carry_seen = 0;
        crossing();
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_h1", 32'(h1), 32'(7'b1000000));
        chk("carry_cycles", 32'(carry_seen), 32'd1);

        // Reset between ticks at 57
        reach(57);
        run(DIV / 2);
        reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_carry", 32'(carry), 32'd0);
        chk("async_h0", 32'(h0), 32'(7'b1000000));
        run(2);
        reset = 1'b1;
        run(3 * DIV);
        chk("after_rst_count", 32'(count), 32'd0);

        // Reset landing in the increment cycle drops the pending increment
        reach(3);
        redInput = 8'h04;
        found = 1'b0;
        for (int i = 0; i < 2 * DIV && !found; i++) begin
            cycle();
            if (m_due == m_cyc) found = 1'b1;
        end
        chk("inc_cycle_found", 32'(found), 32'd1);
        redInput = 8'd0;
        reset = 1'b0;
        #1;
        chk("inc_rst_count", 32'(count), 32'd0);
        run(2);
        reset = 1'b1;
        run(2 * DIV);
        chk("no_late_inc", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
